// File: rtl/riscy_mdu_seq.sv
`default_nettype none
// ============================================================================
// Module      : riscy_mdu_seq
// Description : Iterative RV32M/RV64M multiply/divide unit. One radix-2
//               shift-add (multiply) or restoring shift-subtract (divide)
//               step per clock, valid/ready handshakes on both sides.
// Revision    : 1.0 - initial release
// ============================================================================
module riscy_mdu_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] rd_o,
    output logic [3:0]      flags_o
);

    localparam int CW = (XLEN > 1) ? $clog2(XLEN) : 1;

    localparam logic [XLEN-1:0] c_ONE      = {{(XLEN-1){1'b0}}, 1'b1};
    localparam logic [XLEN-1:0] c_ALL_ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] c_MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CW-1:0]   c_LAST     = CW'(XLEN - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [2:0]          op_q, op_d;
    logic [XLEN-1:0]     amag_q, amag_d;     // multiplicand, or dividend shifting into quotient
    logic [XLEN-1:0]     bmag_q, bmag_d;     // divisor magnitude
    logic [2*XLEN-1:0]   prod_q, prod_d;     // {accumulator, multiplier}
    logic [XLEN-1:0]     rem_q, rem_d;       // partial remainder
    logic                negq_q, negq_d;     // product / quotient must be negated
    logic                negr_q, negr_d;     // remainder must be negated (dividend sign)
    logic [XLEN-1:0]     rd_q, rd_d;
    logic [3:0]          flags_q, flags_d;
    logic                out_valid_q, out_valid_d;

    // Operand decode on the request bus
    logic            w_sgn_a;
    logic            w_sgn_b;
    logic            w_neg_a;
    logic            w_neg_b;
    logic [XLEN-1:0] w_mag_a;
    logic [XLEN-1:0] w_mag_b;
    logic            w_div_zero;
    logic            w_div_ovf;

    // Iteration datapath
    logic [XLEN:0]   w_mul_sum;
    logic [XLEN:0]   w_div_shift;
    logic [XLEN:0]   w_div_diff;

    // Sign-corrected results
    logic [2*XLEN-1:0] w_prod_fix;
    logic [XLEN-1:0]   w_quot_fix;
    logic [XLEN-1:0]   w_rem_fix;

    // Status flags always derive from the final rd value
    function automatic logic [3:0] f_flags(input logic [XLEN-1:0] r,
                                           input logic ovf, input logic dz);
        return {r[XLEN-1], (r == '0), dz, ovf};
    endfunction

    // Signedness: MULH and DIV/REM are signed x signed, MULHSU signed x unsigned
    always_comb begin
        w_sgn_a    = (op_i == 3'b001) || (op_i == 3'b010) ||
                     (op_i == 3'b100) || (op_i == 3'b110);
        w_sgn_b    = (op_i == 3'b001) || (op_i == 3'b100) || (op_i == 3'b110);
        w_neg_a    = w_sgn_a && rs1_i[XLEN-1];
        w_neg_b    = w_sgn_b && rs2_i[XLEN-1];
        w_mag_a    = w_neg_a ? ((~rs1_i) + c_ONE) : rs1_i;
        w_mag_b    = w_neg_b ? ((~rs2_i) + c_ONE) : rs2_i;
        w_div_zero = op_i[2] && (rs2_i == '0);
        w_div_ovf  = op_i[2] && !op_i[0] && (rs1_i == c_MIN_NEG) && (rs2_i == c_ALL_ONES);
    end

    // One shift-add or shift-subtract step, and the final sign fix-up
    always_comb begin
        w_mul_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} +
                      (prod_q[0] ? {1'b0, amag_q} : {(XLEN+1){1'b0}});
        w_div_shift = {rem_q, amag_q[XLEN-1]};
        w_div_diff  = w_div_shift - {1'b0, bmag_q};
        w_prod_fix  = negq_q ? ((~prod_q) + {{(2*XLEN-1){1'b0}}, 1'b1}) : prod_q;
        w_quot_fix  = negq_q ? ((~amag_q) + c_ONE) : amag_q;
        w_rem_fix   = negr_q ? ((~rem_q) + c_ONE) : rem_q;
    end

    // Next-state and datapath update for IDLE/CALC/FIX/DONE
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        amag_d      = amag_q;
        bmag_d      = bmag_q;
        prod_d      = prod_q;
        rem_d       = rem_q;
        negq_d      = negq_q;
        negr_d      = negr_q;
        rd_d        = rd_q;
        flags_d     = flags_q;
        out_valid_d = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (in_valid_i) begin
                    op_d   = op_i;
                    amag_d = w_mag_a;
                    bmag_d = w_mag_b;
                    prod_d = {{XLEN{1'b0}}, w_mag_b};
                    rem_d  = '0;
                    negq_d = w_neg_a ^ w_neg_b;
                    negr_d = w_neg_a;
                    cnt_d  = '0;
                    if (w_div_zero) begin
                        rd_d    = op_i[1] ? rs1_i : c_ALL_ONES;
                        flags_d = f_flags(op_i[1] ? rs1_i : c_ALL_ONES, 1'b0, 1'b1);
                        state_d = S_DONE;
                    end else if (w_div_ovf) begin
                        rd_d    = op_i[1] ? '0 : rs1_i;
                        flags_d = f_flags(op_i[1] ? '0 : rs1_i, 1'b1, 1'b0);
                        state_d = S_DONE;
                    end else begin
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                if (!op_q[2]) begin
                    prod_d = {w_mul_sum, prod_q[XLEN-1:1]};
                end else if (!w_div_diff[XLEN]) begin
                    rem_d  = w_div_diff[XLEN-1:0];
                    amag_d = {amag_q[XLEN-2:0], 1'b1};
                end else begin
                    rem_d  = w_div_shift[XLEN-1:0];
                    amag_d = {amag_q[XLEN-2:0], 1'b0};
                end
                if (cnt_q == c_LAST) begin
                    cnt_d   = '0;
                    state_d = S_FIX;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_FIX: begin
                unique case (op_q)
                    3'b000:                 rd_d = w_prod_fix[XLEN-1:0];
                    3'b001, 3'b010, 3'b011: rd_d = w_prod_fix[2*XLEN-1:XLEN];
                    3'b100, 3'b101:         rd_d = w_quot_fix;
                    default:                rd_d = w_rem_fix;
                endcase
                flags_d = f_flags(rd_d, 1'b0, 1'b0);
                state_d = S_DONE;
            end
            default: begin
                // out_valid trails DONE entry by one edge so rd/flags are settled first
                if (out_valid_q && out_ready_i) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b0;
                end else begin
                    out_valid_d = 1'b1;
                end
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            op_q        <= '0;
            amag_q      <= '0;
            bmag_q      <= '0;
            prod_q      <= '0;
            rem_q       <= '0;
            negq_q      <= 1'b0;
            negr_q      <= 1'b0;
            rd_q        <= '0;
            flags_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            amag_q      <= amag_d;
            bmag_q      <= bmag_d;
            prod_q      <= prod_d;
            rem_q       <= rem_d;
            negq_q      <= negq_d;
            negr_q      <= negr_d;
            rd_q        <= rd_d;
            flags_q     <= flags_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready_o  = (state_q == S_IDLE);
    assign out_valid_o = out_valid_q;
    assign rd_o        = rd_q;
    assign flags_o     = flags_q;

endmodule
`default_nettype wire

// File: tb/tb_riscy_mdu_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_riscy_mdu_seq
// Description : Self-checking bench for riscy_mdu_seq at XLEN=32 and XLEN=8,
//               directed cases plus random operations against an arithmetic
//               reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_riscy_mdu_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        in_valid32 = 1'b0, out_ready32 = 1'b0;
    logic [2:0]  op32 = '0;
    logic [31:0] rs1_32 = '0, rs2_32 = '0;
    logic        in_ready32, out_valid32;
    logic [31:0] rd32;
    logic [3:0]  flags32;

    logic        in_valid8 = 1'b0, out_ready8 = 1'b0;
    logic [2:0]  op8 = '0;
    logic [7:0]  rs1_8 = '0, rs2_8 = '0;
    logic        in_ready8, out_valid8;
    logic [7:0]  rd8;
    logic [3:0]  flags8;

    int checks   = 0;
    int failures = 0;

    riscy_mdu_seq #(.XLEN(32)) u_dut32 (
        .clk(clk), .rst(rst),
        .in_valid_i(in_valid32), .in_ready_o(in_ready32),
        .op_i(op32), .rs1_i(rs1_32), .rs2_i(rs2_32),
        .out_valid_o(out_valid32), .out_ready_i(out_ready32),
        .rd_o(rd32), .flags_o(flags32)
    );

    riscy_mdu_seq #(.XLEN(8)) u_dut8 (
        .clk(clk), .rst(rst),
        .in_valid_i(in_valid8), .in_ready_o(in_ready8),
        .op_i(op8), .rs1_i(rs1_8), .rs2_i(rs2_8),
        .out_valid_o(out_valid8), .out_ready_i(out_ready8),
        .rd_o(rd8), .flags_o(flags8)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: RISC-V M-extension semantics computed with 64-bit arithmetic
    function automatic void model(input int w, input logic [2:0] op,
                                  input logic [63:0] ai, input logic [63:0] bi,
                                  output logic [63:0] rd, output logic [3:0] fl,
                                  output int lat);
        longint unsigned mask, a, b, pu;
        longint          sa, sb, ps;
        logic            ovf, dz;
        mask = (64'd1 << w) - 64'd1;
        a    = ai & mask;
        b    = bi & mask;
        sa   = a[w-1] ? longint'(a) - longint'(64'd1 << w) : longint'(a);
        sb   = b[w-1] ? longint'(b) - longint'(64'd1 << w) : longint'(b);
        ovf  = 1'b0;
        dz   = 1'b0;
        lat  = w + 2;
        case (op)
            3'd0: rd = (a * b) & mask;
            3'd1: begin ps = sa * sb;          rd = 64'(ps >>> w) & mask; end
            3'd2: begin ps = sa * longint'(b); rd = 64'(ps >>> w) & mask; end
            3'd3: begin pu = a * b;            rd = (pu >> w) & mask;     end
            default: begin
                if (b == 0) begin
                    dz  = 1'b1;
                    lat = 1;
                    rd  = op[1] ? a : mask;
                end else if (!op[0] && a == (64'd1 << (w - 1)) && b == mask) begin
                    ovf = 1'b1;
                    lat = 1;
                    rd  = op[1] ? 64'd0 : a;
                end else begin
                    case (op)
                        3'd4:    rd = 64'(sa / sb) & mask;
                        3'd5:    rd = a / b;
                        3'd6:    rd = 64'(sa % sb) & mask;
                        default: rd = a % b;
                    endcase
                end
            end
        endcase
        fl = {rd[w-1], rd == 64'd0, dz, ovf};
    endfunction

    function automatic logic rdy(input int w);
        return (w == 32) ? in_ready32 : in_ready8;
    endfunction
    function automatic logic vld(input int w);
        return (w == 32) ? out_valid32 : out_valid8;
    endfunction
    function automatic logic [63:0] res(input int w);
        return (w == 32) ? {32'd0, rd32} : {56'd0, rd8};
    endfunction
    function automatic logic [3:0] flg(input int w);
        return (w == 32) ? flags32 : flags8;
    endfunction

    task automatic drive(input int w, input logic v, input logic [2:0] op,
                         input logic [63:0] a, input logic [63:0] b);
        if (w == 32) begin
            in_valid32 = v; op32 = op; rs1_32 = a[31:0]; rs2_32 = b[31:0];
        end else begin
            in_valid8 = v; op8 = op; rs1_8 = a[7:0]; rs2_8 = b[7:0];
        end
    endtask

    task automatic set_ready(input int w, input logic v);
        if (w == 32) out_ready32 = v;
        else         out_ready8  = v;
    endtask

    // Issue one operation, check latency/result/flags, optionally stall, then hand off
    task automatic run_op(input int w, input logic [2:0] op, input logic [63:0] a,
                          input logic [63:0] b, input bit bp, input string tag);
        logic [63:0] erd;
        logic [3:0]  efl;
        int          elat;
        int          cyc;
        model(w, op, a, b, erd, efl, elat);
        check({tag, "_in_ready_idle"}, 64'(rdy(w)), 64'd1);
        drive(w, 1'b1, op, a, b);
        @(posedge clk); #1;
        drive(w, 1'b0, 3'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
        check({tag, "_in_ready_busy"}, 64'(rdy(w)), 64'd0);
        cyc = 0;
        while (!vld(w) && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, "_latency"}, 64'(cyc), 64'(elat));
        check({tag, "_rd"},      res(w),     erd);
        check({tag, "_flags"},   64'(flg(w)), 64'(efl));
        if (bp) begin
            for (int i = 0; i < 10; i++) begin
                drive(w, i[0], 3'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
                @(posedge clk); #1;
                check({tag, "_bp_valid"}, 64'(vld(w)),  64'd1);
                check({tag, "_bp_rd"},    res(w),       erd);
                check({tag, "_bp_flags"}, 64'(flg(w)),  64'(efl));
                check({tag, "_bp_ready"}, 64'(rdy(w)),  64'd0);
            end
            drive(w, 1'b0, 3'd0, 64'd0, 64'd0);
        end
        set_ready(w, 1'b1);
        @(posedge clk); #1;
        set_ready(w, 1'b0);
        check({tag, "_handoff_valid"}, 64'(vld(w)), 64'd0);
        check({tag, "_handoff_ready"}, 64'(rdy(w)), 64'd1);
        check({tag, "_rd_held"},       res(w),      erd);
    endtask

    function automatic logic [63:0] pick(input int w);
        logic [63:0] m;
        m = (64'd1 << w) - 64'd1;
        case ($urandom_range(0, 5))
            0:       return 64'd0;
            1:       return 64'd1;
            2:       return m;
            3:       return 64'd1 << (w - 1);
            4:       return 64'($urandom_range(0, 40));
            default: return {$urandom, $urandom} & m;
        endcase
    endfunction

    initial begin : main
        int  cyc;
        bit  saw_valid;
        logic [63:0] a, b;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("reset_rd",        64'(rd32),        64'd0);
        check("reset_flags",     64'(flags32),     64'd0);
        check("reset_out_valid", 64'(out_valid32), 64'd0);
        check("reset_in_ready",  64'(in_ready32),  64'd1);
        rst = 1'b0;
        @(posedge clk); #1;

        // Abort an operation mid-CALC with reset
        drive(32, 1'b1, 3'd0, 64'd7, 64'd6);
        @(posedge clk); #1;
        drive(32, 1'b0, 3'd0, 64'd0, 64'd0);
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b1;
        drive(32, 1'b1, 3'd0, 64'd9, 64'd9);
        #1;
        check("abort_out_valid", 64'(out_valid32), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        drive(32, 1'b0, 3'd0, 64'd0, 64'd0);
        rst = 1'b0;
        #1;
        check("abort_in_ready", 64'(in_ready32), 64'd1);
        saw_valid = 1'b0;
        for (cyc = 0; cyc < 40; cyc++) begin
            @(posedge clk); #1;
            if (out_valid32) saw_valid = 1'b1;
        end
        check("abort_no_result", 64'(saw_valid), 64'd0);
        run_op(32, 3'd0, 64'd3, 64'd4, 1'b0, "mul_after_abort");

        // Directed multiplies, divides and fast paths
        run_op(32, 3'd0, 64'hFFFFFFFF, 64'd2, 1'b0, "mul");
        run_op(32, 3'd1, 64'hFFFFFFFF, 64'd2, 1'b0, "mulh");
        run_op(32, 3'd3, 64'hFFFFFFFF, 64'd2, 1'b0, "mulhu");
        run_op(32, 3'd2, 64'hFFFFFFFF, 64'd2, 1'b0, "mulhsu");
        run_op(32, 3'd4, 64'hFFFFFFEC, 64'd3, 1'b0, "div_neg");
        run_op(32, 3'd6, 64'hFFFFFFEC, 64'd3, 1'b0, "rem_neg");
        run_op(32, 3'd5, 64'd20, 64'd20, 1'b0, "divu_eq");
        run_op(32, 3'd7, 64'd20, 64'd20, 1'b0, "remu_eq");
        run_op(32, 3'd5, 64'd5, 64'd0, 1'b0, "divu_zero");
        run_op(32, 3'd6, 64'd5, 64'd0, 1'b0, "rem_zero");
        run_op(32, 3'd4, 64'h80000000, 64'hFFFFFFFF, 1'b0, "div_ovf");
        run_op(32, 3'd6, 64'h80000000, 64'hFFFFFFFF, 1'b0, "rem_ovf");

        // Backpressure on both a slow and a fast-path result
        run_op(32, 3'd1, 64'h12345678, 64'h9ABCDEF0, 1'b1, "bp_mulh");
        run_op(32, 3'd4, 64'd77, 64'd0, 1'b1, "bp_divzero");

        // Narrow instance
        run_op(8, 3'd4, 64'h80, 64'hFF, 1'b0, "x8_div_ovf");
        run_op(8, 3'd3, 64'hFF, 64'hFF, 1'b0, "x8_mulhu");

        // Random operations at both widths
        for (int i = 0; i < 40; i++) begin
            a = pick(32);
            b = pick(32);
            run_op(32, 3'($urandom), a, b, 1'b0, "rnd32");
        end
        for (int i = 0; i < 30; i++) begin
            a = pick(8);
            b = pick(8);
            run_op(8, 3'($urandom), a, b, 1'b0, "rnd8");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
